delay_probe_ctrl: RTL and testbench
===================================

// Module: delay_probe_ctrl
// PURPOSE
//  Sequences round-trip delay probes on the tx_clk domain.
//  - Requests one test frame from the frame generator.
//  - Timestamps the frame_sent and frame_caught pulses against the free-running time counter.
//  - Reports each delay, or a loss on timeout; spaces probes by a gap.
//  - Keeps min/max/lost statistics over a run of num_probes probes.
//  Sits between the host control regs, the frame generator and the time counter.
// PARAMETERS
//  CNT_W    20       width of time counter, timestamps and delays
//  PROBE_W  8        width of probe count / lost count
//  TIMEOUT  500000   cycles in WAIT_CATCH before a probe is declared lost (< 2**CNT_W)
//  GAP_CYC  1000     idle cycles between end of one probe and next send_req (>= 1)
// PORTS
//  tx_clk        in   1        single clock, rising edge
//  reset         in   1        asynchronous, active-high
//  start         in   1        1-cycle pulse: begin a run; ignored while busy
//  num_probes    in   PROBE_W  probes in the run; sampled on the start cycle
//  time_now      in   CNT_W    free-running counter value (wraps)
//  send_req      out  1        level: request one frame; held until frame_sent
//  frame_sent    in   1        1-cycle pulse: frame left the MAC
//  frame_caught  in   1        1-cycle pulse: the probe frame returned
//  busy          out  1        high from the cycle after start to the cycle done pulses
//  meas_valid    out  1        1-cycle pulse: meas_delay / meas_lost valid
//  meas_delay    out  CNT_W    delay of the last probe; 0 if lost
//  meas_lost     out  1        qualifies meas_valid: the probe timed out
//  lost_cnt      out  PROBE_W  lost probes in the current/last run
//  min_delay     out  CNT_W    min over caught probes (all-ones if none)
//  max_delay     out  CNT_W    max over caught probes (0 if none)
//  done          out  1        1-cycle pulse: run complete
// BEHAVIOUR
//  Reset (async, any state) -> IDLE.
//   - All outputs 0, except min_delay = all-ones.
//   - An in-flight probe is abandoned: no meas_valid, no done.
//  States: IDLE, SEND, WAIT_CATCH, GAP, FIN.
//  IDLE  start & num_probes!=0 -> SEND: clear lost_cnt/min/max, load remaining=num_probes.
//        start & num_probes==0 -> FIN (done pulses the next cycle, no probes).
//  SEND  send_req=1. On frame_sent:
//        - t_sent<=time_now, timeout cnt<=0, -> WAIT_CATCH.
//        - frame_caught in SEND (including same cycle as frame_sent) is ignored.
//  WAIT_CATCH  timeout cnt increments each cycle.
//        frame_caught -> delay = (time_now - t_sent) mod 2**CNT_W, i.e. wrap-safe.
//         - meas_valid=1, meas_lost=0 registered next cycle.
//         - min/max updated with this delay in the same cycle.
//        cnt==TIMEOUT-1 without catch -> meas_valid=1, meas_lost=1, meas_delay=0.
//         - lost_cnt++, saturating at all-ones.
//        Catch on the same cycle as the timeout: catch wins, not lost.
//        Either outcome: remaining--. Then remaining==0 -> FIN, else -> GAP.
//  GAP   count GAP_CYC cycles, then -> SEND.
//        Late frame_caught here is ignored (no stats change).
//  FIN   done=1 for one cycle, busy drops the same cycle, -> IDLE.
//        Stats hold until the next start.
//  Latency
//   - frame_caught -> meas_valid: 1 cycle.
//   - frame_sent -> send_req low: send_req is registered, so it drops the cycle after frame_sent.
//  start while busy: ignored. All outputs are registered.
// STRUCTURE
//  Shared package delay_pkg:
//   - state encoding (localparam/typedef).
//   - CNT_W default.
//   - function wrap_sub(a,b) for modular timestamp difference (also used by timer).
//  One sub-module, probe_stats:
//   - Inputs: clear, upd, lost, delay.
//   - Outputs: min_delay, max_delay, lost_cnt (saturating).
//   - FSM, timestamp and gap/timeout counters stay in this module.
// TESTING
//  1 Run of 1: start, num_probes=1; sent at time_now=100, caught at 350
//    -> meas_delay=250; min=max=250; done 1 cycle after meas_valid path ends.
//  2 Wrap: sent at 0xFFFF0, caught at 0x00010 -> meas_delay=0x20.
//  3 Loss: num_probes=2, TIMEOUT=50; no catch on probe 1; probe 2 caught after 30
//    -> meas_lost=1 then 0; lost_cnt=1; min=max=30; GAP_CYC cycles between probes.
//  4 Edge races:
//    - catch on the timeout cycle -> counted as caught.
//    - caught during SEND or GAP -> ignored.
//    - start while busy -> no effect.
//  5 num_probes=0 -> done pulses, no send_req, stats cleared (min=all-ones).
//  6 Reset asserted in WAIT_CATCH
//    -> all outputs at reset values asynchronously; no meas_valid/done afterward.

Source files
------------

// File: rtl/delay_pkg.sv
// Shared types and helpers for the delay probe controller and its neighbours.
package delay_pkg;

    // Default width of the time counter, timestamps and delays.
    localparam int unsigned CNT_W_DEF = 20;

    // Width used by wrap_sub; callers truncate the result to their own width.
    localparam int unsigned TS_W = 32;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWaitCatch,
        StGap,
        StFin
    } state_e;

    // Modular timestamp difference. The low N bits of the result are
    // (a - b) mod 2**N for any N <= TS_W, so a wrapped counter is handled.
    function automatic logic [TS_W-1:0] wrap_sub(input logic [TS_W-1:0] a,
                                                 input logic [TS_W-1:0] b);
        return a - b;
    endfunction

endpackage

// File: rtl/delay_probe_ctrl_if.sv
// Host / frame generator / time counter signals seen by the probe controller.
interface delay_probe_ctrl_if
    import delay_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned PROBE_W = 8
) ();

    logic               start;
    logic [PROBE_W-1:0] num_probes;
    logic [CNT_W-1:0]   time_now;
    logic               send_req;
    logic               frame_sent;
    logic               frame_caught;
    logic               busy;
    logic               meas_valid;
    logic [CNT_W-1:0]   meas_delay;
    logic               meas_lost;
    logic [PROBE_W-1:0] lost_cnt;
    logic [CNT_W-1:0]   min_delay;
    logic [CNT_W-1:0]   max_delay;
    logic               done;

    // Environment side: host regs, frame generator and time counter.
    modport master (
        output start, num_probes, time_now, frame_sent, frame_caught,
        input  send_req, busy, meas_valid, meas_delay, meas_lost,
        input  lost_cnt, min_delay, max_delay, done
    );

    // Controller side.
    modport slave (
        input  start, num_probes, time_now, frame_sent, frame_caught,
        output send_req, busy, meas_valid, meas_delay, meas_lost,
        output lost_cnt, min_delay, max_delay, done
    );

endinterface

// File: rtl/probe_stats.sv
// Per-run statistics: min/max over caught probes and a saturating lost count.
module probe_stats #(
    parameter int unsigned CNT_W   = 20,
    parameter int unsigned PROBE_W = 8
) (
    input  logic               tx_clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               upd,
    input  logic               lost,
    input  logic [CNT_W-1:0]   delay,
    output logic [CNT_W-1:0]   min_delay,
    output logic [CNT_W-1:0]   max_delay,
    output logic [PROBE_W-1:0] lost_cnt
);

    logic [CNT_W-1:0]   min_q;
    logic [CNT_W-1:0]   max_q;
    logic [PROBE_W-1:0] lost_q;

    // Clear at run start; fold in each probe outcome as it is reported.
    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            min_q  <= '1;
            max_q  <= '0;
            lost_q <= '0;
        end else if (clear) begin
            min_q  <= '1;
            max_q  <= '0;
            lost_q <= '0;
        end else if (upd) begin
            if (lost) begin
                if (lost_q != '1) begin
                    lost_q <= lost_q + PROBE_W'(1);
                end
            end else begin
                if (delay < min_q) begin
                    min_q <= delay;
                end
                if (delay > max_q) begin
                    max_q <= delay;
                end
            end
        end
    end

    assign min_delay = min_q;
    assign max_delay = max_q;
    assign lost_cnt  = lost_q;

endmodule

// File: rtl/delay_probe_ctrl.sv
// Round-trip delay probe sequencer: request a frame, timestamp send and catch,
// report the delay or a loss on timeout, then wait a gap before the next probe.
module delay_probe_ctrl
    import delay_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned PROBE_W = 8,
    parameter int unsigned TIMEOUT = 500000,
    parameter int unsigned GAP_CYC = 1000
) (
    input logic               tx_clk,
    input logic               reset,
    delay_probe_ctrl_if.slave bus
);

    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    state_e             state_q;
    logic               send_req_q;
    logic               busy_q;
    logic               meas_valid_q;
    logic [CNT_W-1:0]   meas_delay_q;
    logic               meas_lost_q;
    logic               done_q;
    logic [CNT_W-1:0]   t_sent_q;
    logic [CNT_W-1:0]   to_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [PROBE_W-1:0] remaining_q;

    logic             start_ok;
    logic             catch_hit;
    logic             timeout_hit;
    logic             probe_end;
    logic [CNT_W-1:0] cur_delay;

    // Decode this cycle's events; a catch on the timeout cycle beats the timeout.
    always_comb begin
        start_ok    = (state_q == StIdle) && bus.start;
        catch_hit   = (state_q == StWaitCatch) && bus.frame_caught;
        timeout_hit = (state_q == StWaitCatch) && !bus.frame_caught && (to_cnt_q == TO_LAST);
        probe_end   = catch_hit || timeout_hit;
        cur_delay   = CNT_W'(wrap_sub(TS_W'(bus.time_now), TS_W'(t_sent_q)));
    end

    // Probe sequencer with registered outputs.
    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            send_req_q   <= 1'b0;
            busy_q       <= 1'b0;
            meas_valid_q <= 1'b0;
            meas_delay_q <= '0;
            meas_lost_q  <= 1'b0;
            done_q       <= 1'b0;
            t_sent_q     <= '0;
            to_cnt_q     <= '0;
            gap_cnt_q    <= '0;
            remaining_q  <= '0;
        end else begin
            meas_valid_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        busy_q      <= 1'b1;
                        remaining_q <= bus.num_probes;
                        if (bus.num_probes != '0) begin
                            send_req_q <= 1'b1;
                            state_q    <= StSend;
                        end else begin
                            state_q <= StFin;
                        end
                    end
                end
                StSend: begin
                    if (bus.frame_sent) begin
                        send_req_q <= 1'b0;
                        t_sent_q   <= bus.time_now;
                        to_cnt_q   <= '0;
                        state_q    <= StWaitCatch;
                    end
                end
                StWaitCatch: begin
                    if (probe_end) begin
                        meas_valid_q <= 1'b1;
                        meas_lost_q  <= timeout_hit;
                        meas_delay_q <= catch_hit ? cur_delay : '0;
                        remaining_q  <= remaining_q - PROBE_W'(1);
                        gap_cnt_q    <= '0;
                        state_q      <= (remaining_q == PROBE_W'(1)) ? StFin : StGap;
                    end else begin
                        to_cnt_q <= to_cnt_q + CNT_W'(1);
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        send_req_q <= 1'b1;
                        state_q    <= StSend;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                StFin: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    probe_stats #(
        .CNT_W   (CNT_W),
        .PROBE_W (PROBE_W)
    ) u_stats (
        .tx_clk    (tx_clk),
        .reset     (reset),
        .clear     (start_ok),
        .upd       (probe_end),
        .lost      (timeout_hit),
        .delay     (cur_delay),
        .min_delay (bus.min_delay),
        .max_delay (bus.max_delay),
        .lost_cnt  (bus.lost_cnt)
    );

    assign bus.send_req   = send_req_q;
    assign bus.busy       = busy_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.meas_delay = meas_delay_q;
    assign bus.meas_lost  = meas_lost_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_delay_probe_ctrl.sv
// Bench for delay_probe_ctrl: directed and random probe runs against a model
// that derives delays from the driven timestamps and stats from outcome lists.
module tb_delay_probe_ctrl;

    localparam int CNT_W   = 20;
    localparam int PROBE_W = 8;
    localparam int TIMEOUT = 300;
    localparam int GAP_CYC = 10;
    localparam logic [31:0] MASK = 32'h000F_FFFF;

    logic tx_clk = 1'b0;
    logic reset  = 1'b1;

    delay_probe_ctrl_if #(.CNT_W(CNT_W), .PROBE_W(PROBE_W)) bus ();

    delay_probe_ctrl #(
        .CNT_W   (CNT_W),
        .PROBE_W (PROBE_W),
        .TIMEOUT (TIMEOUT),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .tx_clk (tx_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 tx_clk = ~tx_clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [CNT_W-1:0] tnow = '0;

    // Model of the current run: delays of caught probes and the lost count.
    int unsigned run_delays[$];
    int unsigned run_lost;

    function automatic logic [31:0] exp_min();
        logic [31:0] m = MASK;
        foreach (run_delays[i]) if (run_delays[i] < m) m = run_delays[i];
        return m;
    endfunction

    function automatic logic [31:0] exp_max();
        logic [31:0] m = 0;
        foreach (run_delays[i]) if (run_delays[i] > m) m = run_delays[i];
        return m;
    endfunction

    function automatic logic [31:0] exp_lost();
        return (run_lost > 255) ? 32'd255 : run_lost;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge tx_clk);
        tnow = tnow + 1'b1;
        bus.time_now = tnow;
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_min"},  32'(bus.min_delay), exp_min());
        chk({tag, "_max"},  32'(bus.max_delay), exp_max());
        chk({tag, "_lost"}, 32'(bus.lost_cnt),  exp_lost());
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_send_req"},   32'(bus.send_req),   0);
        chk({tag, "_busy"},       32'(bus.busy),       0);
        chk({tag, "_meas_valid"}, 32'(bus.meas_valid), 0);
        chk({tag, "_meas_delay"}, 32'(bus.meas_delay), 0);
        chk({tag, "_meas_lost"},  32'(bus.meas_lost),  0);
        chk({tag, "_lost_cnt"},   32'(bus.lost_cnt),   0);
        chk({tag, "_min"},        32'(bus.min_delay),  MASK);
        chk({tag, "_max"},        32'(bus.max_delay),  0);
        chk({tag, "_done"},       32'(bus.done),       0);
    endtask

    task automatic wait_send_req();
        int n = 0;
        while (bus.send_req !== 1'b1 && n < 2 * GAP_CYC + 4) begin
            tick();
            n++;
        end
        chk("send_req_seen", 32'(bus.send_req), 1);
    endtask

    task automatic start_run(input int n);
        bus.start      = 1'b1;
        bus.num_probes = PROBE_W'(n);
        tick();
        bus.start = 1'b0;
        run_delays.delete();
        run_lost = 0;
        chk("start_busy", 32'(bus.busy), 1);
        chk("start_send_req", 32'(bus.send_req), (n != 0) ? 1 : 0);
        chk_stats("start_clear");
    endtask

    // One probe: sent at t_sent; caught d cycles later, or left to time out.
    // With poke, frame_caught is pulsed in SEND and on the frame_sent cycle.
    task automatic run_probe(input logic [CNT_W-1:0] t_sent, input bit caught, input int d,
                             input bit poke);
        int n;
        bit early;
        logic [CNT_W-1:0] t_catch;
        wait_send_req();
        if (poke) begin
            bus.frame_caught = 1'b1;
            tick();
            bus.frame_caught = 1'b0;
            chk("send_req_hold", 32'(bus.send_req), 1);
        end
        tnow             = t_sent;
        bus.time_now     = tnow;
        bus.frame_sent   = 1'b1;
        bus.frame_caught = poke;
        tick();
        bus.frame_sent   = 1'b0;
        bus.frame_caught = 1'b0;
        chk("send_req_drop", 32'(bus.send_req), 0);
        n     = caught ? d : TIMEOUT;
        early = bus.meas_valid;
        for (int i = 1; i < n; i++) begin
            tick();
            early |= bus.meas_valid;
        end
        t_catch = tnow;
        if (caught) bus.frame_caught = 1'b1;
        tick();
        bus.frame_caught = 1'b0;
        chk("meas_early", 32'(early), 0);
        if (caught) run_delays.push_back((32'(t_catch) - 32'(t_sent)) & MASK);
        else run_lost++;
        chk("meas_valid", 32'(bus.meas_valid), 1);
        chk("meas_lost", 32'(bus.meas_lost), caught ? 0 : 1);
        chk("meas_delay", 32'(bus.meas_delay),
            caught ? ((32'(t_catch) - 32'(t_sent)) & MASK) : 0);
        chk_stats("probe");
    endtask

    // Gap after a non-final probe; poke injects a late catch and a start pulse.
    task automatic check_gap(input bit poke);
        bit seen = 1'b0;
        for (int i = 1; i < GAP_CYC; i++) begin
            if (poke && i == 2) begin
                bus.frame_caught = 1'b1;
                bus.start        = 1'b1;
                bus.num_probes   = 8'd7;
            end
            tick();
            bus.frame_caught = 1'b0;
            bus.start        = 1'b0;
            seen |= bus.meas_valid | bus.send_req;
        end
        chk("gap_quiet", 32'(seen), 0);
        tick();
        chk("gap_len", 32'(bus.send_req), 1);
        chk_stats("gap");
    endtask

    task automatic finish_run();
        chk("fin_busy_before", 32'(bus.busy), 1);
        tick();
        chk("done_pulse", 32'(bus.done), 1);
        chk("done_busy", 32'(bus.busy), 0);
        tick();
        chk("done_clear", 32'(bus.done), 0);
        chk_stats("fin");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit caught;
        bit seen;
        bus.start        = 1'b0;
        bus.num_probes   = '0;
        bus.time_now     = '0;
        bus.frame_sent   = 1'b0;
        bus.frame_caught = 1'b0;
        run_lost         = 0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk_reset_vals("reset");

        // Run of one: sent at 100, caught at 350.
        start_run(1);
        tick();
        chk("send_req_level", 32'(bus.send_req), 1);
        run_probe(20'd100, 1'b1, 250, 1'b0);
        chk("t1_delay", 32'(bus.meas_delay), 250);
        finish_run();

        // Timestamp wrap: sent at 0xFFFF0, caught at 0x00010.
        start_run(1);
        run_probe(20'hFFFF0, 1'b1, 32, 1'b0);
        chk("t2_delay", 32'(bus.meas_delay), 32'h20);
        finish_run();

        // Loss then catch after 30.
        start_run(2);
        run_probe(20'h01234, 1'b0, 0, 1'b0);
        check_gap(1'b0);
        run_probe(20'h05000, 1'b1, 30, 1'b0);
        chk("t3_lost", 32'(bus.lost_cnt), 1);
        chk("t3_min", 32'(bus.min_delay), 30);
        finish_run();

        // Races: catch on timeout cycle, catch in SEND/GAP, start while busy.
        start_run(3);
        run_probe(20'h00400, 1'b1, TIMEOUT, 1'b1);
        check_gap(1'b1);
        run_probe(20'h00800, 1'b1, 5, 1'b0);
        check_gap(1'b0);
        run_probe(20'h00C00, 1'b1, 17, 1'b1);
        chk("t4_lost", 32'(bus.lost_cnt), 0);
        finish_run();

        // Empty run: done without any probe, stats cleared.
        start_run(0);
        tick();
        chk("t5_done", 32'(bus.done), 1);
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_send_req", 32'(bus.send_req), 0);
        chk_stats("t5");

        // Random runs.
        for (int r = 0; r < 2; r++) begin
            n = $urandom_range(2, 4);
            start_run(n);
            for (int p = 0; p < n; p++) begin
                caught = ($urandom_range(0, 3) != 0);
                run_probe(CNT_W'($urandom), caught, $urandom_range(1, TIMEOUT), 1'b0);
                if (p < n - 1) check_gap(1'b0);
            end
            finish_run();
        end

        // Asynchronous reset while waiting for the catch.
        start_run(1);
        wait_send_req();
        bus.frame_sent = 1'b1;
        tick();
        bus.frame_sent = 1'b0;
        repeat (5) tick();
        chk("t6_busy_before", 32'(bus.busy), 1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("t6_async");
        tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.frame_caught = (i == 0);
            bus.frame_sent   = (i == 1);
            tick();
            seen |= bus.meas_valid | bus.done | bus.send_req | bus.busy;
        end
        bus.frame_caught = 1'b0;
        bus.frame_sent   = 1'b0;
        chk("t6_abandoned", 32'(seen), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
